// File: rtl/robo_step_scheduler_if.sv
// Actuator operation handshake between the step scheduler and the motor/vacuum unit.
interface robo_step_scheduler_if;
    logic       act_valid;
    logic [1:0] act_op;
    logic       act_ready;

    modport master (output act_valid, output act_op, input act_ready);
    modport slave  (input act_valid, input act_op, output act_ready);
endinterface

// File: rtl/robo_step_scheduler.sv
// Sequences one Robo mission: sense, sample commands, issue one actuator op per step,
// track pose/heading and stop on budget exhaustion or a fault.
module robo_step_scheduler #(
    parameter int unsigned ROWS          = 10,
    parameter int unsigned COLS          = 20,
    parameter int unsigned ROW_W         = 4,
    parameter int unsigned COL_W         = 5,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned REMOVE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ROW_W-1:0]      start_row,
    input  logic [COL_W-1:0]      start_col,
    input  logic [1:0]            start_dir,
    input  logic [CNT_W-1:0]      move_budget,
    input  logic                  cmd_forward,
    input  logic                  cmd_turn,
    input  logic                  cmd_remove,
    output logic                  sense_req,
    robo_step_scheduler_if.master act,
    output logic [ROW_W-1:0]      row,
    output logic [COL_W-1:0]      col,
    output logic [1:0]            dir,
    output logic [CNT_W-1:0]      moves_done,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [1:0]            fault_code
);
    localparam int unsigned    RC_W   = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
    localparam logic [ROW_W-1:0] ROWS_L = ROW_W'(ROWS);
    localparam logic [COL_W-1:0] COLS_L = COL_W'(COLS);
    localparam logic [1:0] DIR_N = 2'b00, DIR_S = 2'b01, DIR_L = 2'b10, DIR_O = 2'b11;
    localparam logic [1:0] OP_FWD = 2'b00, OP_TURN = 2'b01, OP_REMOVE = 2'b10;
    localparam logic [1:0] FC_BOUND = 2'd1, FC_MULTI = 2'd2, FC_POSE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SENSE, S_SAMPLE, S_ISSUE, S_REMOVING, S_DONE, S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        dir_q, dir_d;
    logic [CNT_W-1:0]  moves_q, moves_d;
    logic [CNT_W-1:0]  budget_q, budget_d;
    logic [1:0]        fcode_q, fcode_d;
    logic [2:0]        cmd_q, cmd_d;       // {remove, turn, forward}
    logic [RC_W-1:0]   rcnt_q, rcnt_d;

    logic              step_end;
    logic              multi_cmd;
    logic              start_ok;
    logic              fwd_blocked;
    logic [ROW_W-1:0]  fwd_row;
    logic [COL_W-1:0]  fwd_col;
    logic [1:0]        left_dir;

    assign multi_cmd = (cmd_q[0] & cmd_q[1]) | (cmd_q[0] & cmd_q[2]) | (cmd_q[1] & cmd_q[2]);
    assign start_ok  = (start_row != '0) && (start_row <= ROWS_L) &&
                       (start_col != '0) && (start_col <= COLS_L);

    always_comb begin
        fwd_row     = row_q;
        fwd_col     = col_q;
        fwd_blocked = 1'b0;
        left_dir    = DIR_N;
        unique case (dir_q)
            DIR_N: begin fwd_blocked = (row_q == ROW_W'(1)); fwd_row = row_q - ROW_W'(1); left_dir = DIR_O; end
            DIR_S: begin fwd_blocked = (row_q == ROWS_L);    fwd_row = row_q + ROW_W'(1); left_dir = DIR_L; end
            DIR_L: begin fwd_blocked = (col_q == COLS_L);    fwd_col = col_q + COL_W'(1); left_dir = DIR_N; end
            default: begin fwd_blocked = (col_q == COL_W'(1)); fwd_col = col_q - COL_W'(1); left_dir = DIR_S; end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        col_d         = col_q;
        dir_d         = dir_q;
        moves_d       = moves_q;
        budget_d      = budget_q;
        fcode_d       = fcode_q;
        cmd_d         = cmd_q;
        rcnt_d        = rcnt_q;
        step_end      = 1'b0;
        act.act_valid = 1'b0;
        act.act_op    = OP_FWD;

        unique case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    row_d    = start_row;
                    col_d    = start_col;
                    dir_d    = start_dir;
                    budget_d = move_budget;
                    moves_d  = '0;
                    fcode_d  = '0;
                    if (!start_ok) begin
                        state_d = S_FAULT;
                        fcode_d = FC_POSE;
                    end else if (move_budget == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SENSE;
                    end
                end
            end
            S_SENSE: state_d = S_SAMPLE;
            S_SAMPLE: begin
                cmd_d   = {cmd_remove, cmd_turn, cmd_forward};
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (multi_cmd) begin
                    state_d = S_FAULT;
                    fcode_d = FC_MULTI;
                end else if (cmd_q == '0) begin
                    step_end = 1'b1;
                end else if (cmd_q[0] && fwd_blocked) begin
                    state_d = S_FAULT;
                    fcode_d = FC_BOUND;
                end else begin
                    act.act_valid = 1'b1;
                    act.act_op    = cmd_q[0] ? OP_FWD : (cmd_q[1] ? OP_TURN : OP_REMOVE);
                    if (act.act_ready) begin
                        if (cmd_q[0]) begin
                            row_d    = fwd_row;
                            col_d    = fwd_col;
                            step_end = 1'b1;
                        end else if (cmd_q[1]) begin
                            dir_d    = left_dir;
                            step_end = 1'b1;
                        end else begin
                            rcnt_d  = RC_W'(REMOVE_CYCLES - 1);
                            state_d = S_REMOVING;
                        end
                    end
                end
            end
            S_REMOVING: begin
                if (rcnt_q == '0) step_end = 1'b1;
                else              rcnt_d   = rcnt_q - RC_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Every step retires here, whichever path it took.
        if (step_end) begin
            moves_d = moves_q + CNT_W'(1);
            state_d = (moves_d == budget_q) ? S_DONE : S_SENSE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            dir_q    <= '0;
            moves_q  <= '0;
            budget_q <= '0;
            fcode_q  <= '0;
            cmd_q    <= '0;
            rcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            moves_q  <= moves_d;
            budget_q <= budget_d;
            fcode_q  <= fcode_d;
            cmd_q    <= cmd_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign sense_req  = (state_q == S_SENSE);
    assign busy       = (state_q == S_SENSE) || (state_q == S_SAMPLE) ||
                        (state_q == S_ISSUE) || (state_q == S_REMOVING);
    assign done       = (state_q == S_DONE);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fcode_q;
    assign row        = row_q;
    assign col        = col_q;
    assign dir        = dir_q;
    assign moves_done = moves_q;
endmodule

// File: tb/tb_robo_step_scheduler.sv
// Randomized mission bench for robo_step_scheduler with a step-level reference model.
module tb_robo_step_scheduler;
    localparam int ROWS = 10, COLS = 20, ROW_W = 4, COL_W = 5, CNT_W = 24, RC = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [ROW_W-1:0] start_row;
    logic [COL_W-1:0] start_col;
    logic [1:0]       start_dir;
    logic [CNT_W-1:0] move_budget;
    logic             cmd_forward, cmd_turn, cmd_remove;
    logic             sense_req;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [1:0]       dir;
    logic [CNT_W-1:0] moves_done;
    logic             busy, done, fault;
    logic [1:0]       fault_code;

    robo_step_scheduler_if act_if ();

    robo_step_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .CNT_W(CNT_W), .REMOVE_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .start_row(start_row), .start_col(start_col), .start_dir(start_dir),
        .move_budget(move_budget), .cmd_forward(cmd_forward), .cmd_turn(cmd_turn),
        .cmd_remove(cmd_remove), .sense_req(sense_req), .act(act_if),
        .row(row), .col(col), .dir(dir), .moves_done(moves_done),
        .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: mission state after each completed step.
    int m_row, m_col, m_dir, m_moves, m_code, m_steps, m_accepts, m_budget;
    bit m_fault, m_done;
    int n_sense, n_accept;
    int left_of [4] = '{3, 2, 0, 1};

    task automatic model_start(input int r, input int c, input int d, input int b);
        m_row = r; m_col = c; m_dir = d; m_budget = b;
        m_moves = 0; m_code = 0; m_steps = 0; m_accepts = 0;
        m_fault = 0; m_done = 0;
        if (r < 1 || r > ROWS || c < 1 || c > COLS) begin
            m_fault = 1; m_code = 3;
        end else if (b == 0) begin
            m_done = 1;
        end
    endtask

    task automatic model_step(input bit f, input bit t, input bit rm, output bit issue, output int op);
        int nr, nc;
        issue = 0; op = 0; m_steps++;
        if (int'(f) + int'(t) + int'(rm) > 1) begin
            m_fault = 1; m_code = 2;
        end else if (f) begin
            nr = m_row; nc = m_col;
            case (m_dir)
                0: nr = nr - 1;
                1: nr = nr + 1;
                2: nc = nc + 1;
                default: nc = nc - 1;
            endcase
            if (nr < 1 || nr > ROWS || nc < 1 || nc > COLS) begin
                m_fault = 1; m_code = 1;
            end else begin
                issue = 1; op = 0; m_row = nr; m_col = nc;
            end
        end else if (t) begin
            issue = 1; op = 1; m_dir = left_of[m_dir];
        end else if (rm) begin
            issue = 1; op = 2;
        end
        if (issue) m_accepts++;
        if (!m_fault) begin
            m_moves++;
            if (m_moves == m_budget) m_done = 1;
        end
    endtask

    // mode: 0 random, 1 forward, 2 turn, 3 remove, 4 forward+remove
    task automatic pick_cmd(input int mode, output bit f, output bit t, output bit rm);
        int k;
        f = 0; t = 0; rm = 0;
        case (mode)
            1: f = 1;
            2: t = 1;
            3: rm = 1;
            4: begin f = 1; rm = 1; end
            default: begin
                k = $urandom_range(0, 15);
                if (k <= 4) f = 1;
                else if (k <= 8) t = 1;
                else if (k <= 10) rm = 1;
                else if (k == 13) begin f = 1; rm = 1; end
                else if (k == 14) begin t = 1; rm = 1; end
                else if (k == 15) begin f = 1; t = 1; rm = 1; end
            end
        endcase
    endtask

    task automatic run_mission(input int r, input int c, input int d, input int b, input int mode,
                               input int stall_first, input bit rand_ready, input bit busy_start);
        bit cf, ct, cr, step_issue, step_acc, drive_step, pending;
        int step_op, rem_cnt, stall_left, cyc;
        cf = 0; ct = 0; cr = 0;
        @(negedge clock);
        start = 1'b1;
        start_row = r[ROW_W-1:0];
        start_col = c[COL_W-1:0];
        start_dir = d[1:0];
        move_budget = b[CNT_W-1:0];
        act_if.act_ready = 1'b0;
        {cmd_remove, cmd_turn, cmd_forward} = 3'($urandom);
        model_start(r, c, d, b);
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({fault, fault_code, done} !== {m_fault, m_code[1:0], m_done}) begin
            errors++;
            $display("FAIL start_state got fault=%b code=%0d done=%b exp fault=%b code=%0d done=%b",
                     fault, fault_code, done, m_fault, m_code, m_done);
        end
        n_sense = 0; n_accept = 0; pending = 0; step_issue = 0; step_acc = 0;
        step_op = 0; rem_cnt = -1; stall_left = stall_first; cyc = 0;
        while (cyc < 3000) begin
            if (act_if.act_valid === 1'b1) begin
                checks++;
                if (!step_issue || step_acc || act_if.act_op !== step_op[1:0]) begin
                    errors++;
                    $display("FAIL act_handshake step %0d got op=%0d exp valid=%b op=%0d",
                             m_steps, act_if.act_op, step_issue && !step_acc, step_op);
                end
            end
            if (rem_cnt >= 0) begin
                if (sense_req || done || fault) begin
                    checks++;
                    if (rem_cnt != RC) begin
                        errors++;
                        $display("FAIL remove_cycles got %0d exp %0d", rem_cnt, RC);
                    end
                    rem_cnt = -1;
                end else begin
                    rem_cnt++;
                end
            end
            if (done || fault) break;
            if (sense_req) begin
                checks++;
                if ({row, col, dir, moves_done} !==
                    {m_row[ROW_W-1:0], m_col[COL_W-1:0], m_dir[1:0], m_moves[CNT_W-1:0]}) begin
                    errors++;
                    $display("FAIL step_pose got r=%0d c=%0d d=%0d m=%0d exp r=%0d c=%0d d=%0d m=%0d",
                             row, col, dir, moves_done, m_row, m_col, m_dir, m_moves);
                end
                n_sense++;
                pick_cmd(mode, cf, ct, cr);
                model_step(cf, ct, cr, step_issue, step_op);
                step_acc = 0;
            end
            drive_step = pending;
            pending = sense_req;
            if (drive_step) {cmd_remove, cmd_turn, cmd_forward} = {cr, ct, cf};
            else            {cmd_remove, cmd_turn, cmd_forward} = 3'($urandom);
            if (act_if.act_valid && stall_left > 0) begin
                act_if.act_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                act_if.act_ready = ($urandom_range(0, 2) != 0);
            end else begin
                act_if.act_ready = 1'b1;
            end
            if (act_if.act_valid && act_if.act_ready) begin
                step_acc = 1;
                n_accept++;
                if (step_op == 2) rem_cnt = 0;
            end
            if (busy_start && busy && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
                start_row = 4'($urandom);
                start_col = 5'($urandom);
                start_dir = 2'($urandom);
                move_budget = 24'($urandom_range(0, 9));
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        act_if.act_ready = 1'b0;
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL mission_timeout got %0d cycles exp termination", cyc);
        end
        checks++;
        if ({done, fault, fault_code} !== {m_done, m_fault, m_code[1:0]}) begin
            errors++;
            $display("FAIL end_status got done=%b fault=%b code=%0d exp done=%b fault=%b code=%0d",
                     done, fault, fault_code, m_done, m_fault, m_code);
        end
        checks++;
        if ({row, col, dir, moves_done} !==
            {m_row[ROW_W-1:0], m_col[COL_W-1:0], m_dir[1:0], m_moves[CNT_W-1:0]}) begin
            errors++;
            $display("FAIL end_pose got r=%0d c=%0d d=%0d m=%0d exp r=%0d c=%0d d=%0d m=%0d",
                     row, col, dir, moves_done, m_row, m_col, m_dir, m_moves);
        end
        checks++;
        if (n_sense != m_steps || n_accept != m_accepts) begin
            errors++;
            $display("FAIL step_counts got sense=%0d accept=%0d exp sense=%0d accept=%0d",
                     n_sense, n_accept, m_steps, m_accepts);
        end
        checks++;
        if ({busy, act_if.act_valid, sense_req} !== 3'b000) begin
            errors++;
            $display("FAIL end_quiet got busy/valid/sense=%b exp 000", {busy, act_if.act_valid, sense_req});
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        checks++;
        if ({sense_req, act_if.act_valid, act_if.act_op, row, col, dir, moves_done, busy, done, fault, fault_code} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {sense_req, act_if.act_valid, act_if.act_op, row, col, dir,
                     moves_done, busy, done, fault, fault_code});
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({sense_req, busy, done, fault, moves_done} !== 28'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %h exp 0", {sense_req, busy, done, fault, moves_done});
        end
    endtask

    task automatic test_forward;
        run_mission(9, 1, 0, 3, 1, 0, 0, 0);
        checks++;
        if ({row, moves_done, done} !== {4'd6, 24'd3, 1'b1} || n_sense != 3) begin
            errors++;
            $display("FAIL forward_run got row=%0d moves=%0d done=%b sense=%0d exp 6 3 1 3",
                     row, moves_done, done, n_sense);
        end
    endtask

    task automatic test_turn;
        run_mission(5, 5, 0, 4, 2, 0, 1, 0);
        checks++;
        if ({row, col, dir, moves_done} !== {4'd5, 5'd5, 2'd0, 24'd4}) begin
            errors++;
            $display("FAIL turn_run got r=%0d c=%0d d=%0d m=%0d exp 5 5 0 4", row, col, dir, moves_done);
        end
    endtask

    task automatic test_remove_stall;
        run_mission(4, 7, 2, 2, 3, 5, 0, 0);
        checks++;
        if ({row, col, dir, done} !== {4'd4, 5'd7, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL remove_run got r=%0d c=%0d d=%0d done=%b exp 4 7 2 1", row, col, dir, done);
        end
    endtask

    task automatic test_bounds;
        run_mission(1, 3, 0, 2, 1, 0, 1, 0);   // north edge
        run_mission(5, 5, 1, 1, 1, 0, 1, 0);   // next start clears the fault
        run_mission(10, 4, 1, 1, 1, 0, 1, 0);  // south edge
        run_mission(3, 20, 2, 2, 1, 0, 1, 0);  // east edge
        run_mission(3, 2, 3, 3, 1, 0, 1, 0);   // west edge after one step
    endtask

    task automatic test_errors;
        run_mission(5, 5, 0, 3, 4, 0, 1, 0);
        run_mission(5, 0, 0, 3, 1, 0, 1, 0);
        run_mission(11, 5, 0, 3, 1, 0, 1, 0);
        run_mission(5, 21, 0, 3, 1, 0, 1, 0);
        run_mission(5, 5, 0, 0, 1, 0, 1, 0);
    endtask

    task automatic test_random;
        int r, c;
        for (int i = 0; i < 30; i++) begin
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, ROWS));
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, COLS));
            run_mission(r, c, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 0, 0, 1, 1);
        end
    endtask

    task automatic test_reset_mid;
        int waited;
        @(negedge clock);
        start = 1'b1; start_row = 4'd5; start_col = 5'd5; start_dir = 2'd0; move_budget = 24'd2;
        {cmd_remove, cmd_turn, cmd_forward} = 3'b100;
        act_if.act_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        waited = 0;
        while (act_if.act_valid !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (act_if.act_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup got valid=%b exp 1", act_if.act_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (act_if.act_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_valid_drop got %b exp 0", act_if.act_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({sense_req, act_if.act_valid, act_if.act_op, row, col, dir, moves_done, busy, done, fault, fault_code} !== 44'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h exp 0", {sense_req, act_if.act_valid, act_if.act_op, row, col, dir,
                     moves_done, busy, done, fault, fault_code});
        end
        {cmd_remove, cmd_turn, cmd_forward} = 3'b000;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        start_row = '0; start_col = '0; start_dir = '0; move_budget = '0;
        cmd_forward = 1'b0; cmd_turn = 1'b0; cmd_remove = 1'b0;
        act_if.act_ready = 1'b0;
        test_reset;
        test_forward;
        test_turn;
        test_remove_stall;
        test_bounds;
        test_errors;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
